// File: rtl/nbody_step_scheduler_if.sv
// Scheduler bus: control inputs from the register file and issue/write-back strobes to the datapath.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; the datapath accepts one strobe per cycle unconditionally.
interface nbody_step_scheduler_if #(
  parameter int AW = 9
);
  logic          start;
  logic          abort;
  logic [AW:0]   num_bodies;
  logic [15:0]   n_steps;
  logic          busy;
  logic          done;
  logic [15:0]   step_idx;
  logic          first_step;
  logic          rd_valid;
  logic [AW-1:0] rd_tgt;
  logic [AW-1:0] rd_src;
  logic          acc_valid;
  logic [AW-1:0] acc_tgt;
  logic          acc_first;
  logic          acc_last;
  logic          pos_rd_valid;
  logic [AW-1:0] pos_rd_addr;
  logic          pos_wr_en;
  logic [AW-1:0] pos_wr_addr;

  modport master (
    output start, abort, num_bodies, n_steps,
    input  busy, done, step_idx, first_step,
    input  rd_valid, rd_tgt, rd_src,
    input  acc_valid, acc_tgt, acc_first, acc_last,
    input  pos_rd_valid, pos_rd_addr, pos_wr_en, pos_wr_addr
  );

  modport slave (
    input  start, abort, num_bodies, n_steps,
    output busy, done, step_idx, first_step,
    output rd_valid, rd_tgt, rd_src,
    output acc_valid, acc_tgt, acc_first, acc_last,
    output pos_rd_valid, pos_rd_addr, pos_wr_en, pos_wr_addr
  );
endinterface

// File: rtl/nbody_step_scheduler.sv
// N-body timestep sequencer: issues all (tgt,src) pairs, then all position updates, per step.
// Latency: first pair one cycle after start; write-backs delayed RAM+ACCL / RAM+ADD cycles.
// Backpressure: none; one issue per cycle. Optional NBODY_SKIP_SELF_EN drops src==tgt pairs.
module nbody_step_scheduler #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int RAM_LATENCY     = 1,
  parameter int ACCL_LATENCY    = 123,
  parameter int ADD_LATENCY     = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nbody_step_scheduler_if.slave bus
);
  localparam int AW = BODY_ADDR_WIDTH;
  localparam int AD = RAM_LATENCY + ACCL_LATENCY;
  localparam int PD = RAM_LATENCY + ADD_LATENCY;

`ifdef NBODY_SKIP_SELF_EN
  localparam bit SKIP_SELF = 1'b1;
`else
  localparam bit SKIP_SELF = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ACCEL, DRAIN_A, POS, DRAIN_P, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     n_q, n_d;
  logic [15:0]     steps_q, steps_d;
  logic [15:0]     step_q, step_d;
  logic [AW-1:0]   tgt_q, tgt_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   addr_q, addr_d;

  logic [AD-1:0]           acc_vld_q;
  logic [AD-1:0][AW+1:0]   acc_dat_q;
  logic [PD-1:0]           pos_vld_q;
  logic [PD-1:0][AW-1:0]   pos_dat_q;

  logic [AW:0]   nm1, src1, src2;
  logic          row_end, pair_first;
  logic [AW-1:0] src_init;
  logic          acc_pend, pos_pend;

  // Pair-walk helpers: next source (skipping self when enabled) and first/last flags.
  assign nm1        = n_q - 1'b1;
  assign src1       = {1'b0, src_q} + 1'b1;
  assign src2       = (SKIP_SELF && src1 == {1'b0, tgt_q}) ? src1 + 1'b1 : src1;
  assign row_end    = (src2 >= n_q);
  assign src_init   = SKIP_SELF ? AW'(1) : '0;
  assign pair_first = (src_q == ((SKIP_SELF && tgt_q == '0) ? AW'(1) : '0));
  // Drain ends once only the outgoing stage (if any) still holds a valid entry.
  assign acc_pend   = |acc_vld_q[AD-2:0];
  assign pos_pend   = |pos_vld_q[PD-2:0];

  // Next-state and counter updates; abort overrides everything.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    steps_d = steps_q;
    step_d  = step_q;
    tgt_d   = tgt_q;
    src_d   = src_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          n_d     = bus.num_bodies;
          steps_d = (bus.n_steps == 16'd0) ? 16'd1 : bus.n_steps;
          step_d  = 16'd0;
          tgt_d   = '0;
          src_d   = src_init;
          addr_d  = '0;
          if (bus.num_bodies == '0)                        state_d = DONE;
          else if (SKIP_SELF && bus.num_bodies == (AW+1)'(1)) state_d = DRAIN_A;
          else                                             state_d = ACCEL;
        end
      end
      ACCEL: begin
        if (row_end) begin
          src_d = '0;
          if ({1'b0, tgt_q} == nm1) state_d = DRAIN_A;
          else                      tgt_d   = tgt_q + 1'b1;
        end else begin
          src_d = src2[AW-1:0];
        end
      end
      DRAIN_A: begin
        if (!acc_pend) begin
          state_d = POS;
          addr_d  = '0;
        end
      end
      POS: begin
        addr_d = addr_q + 1'b1;
        if ({1'b0, addr_q} == nm1) state_d = DRAIN_P;
      end
      DRAIN_P: begin
        if (!pos_pend) begin
          if (step_q == steps_q - 16'd1) begin
            state_d = DONE;
          end else begin
            step_d  = step_q + 16'd1;
            tgt_d   = '0;
            src_d   = src_init;
            state_d = (SKIP_SELF && n_q == (AW+1)'(1)) ? DRAIN_A : ACCEL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      steps_q <= '0;
      step_q  <= '0;
      tgt_q   <= '0;
      src_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      steps_q <= steps_d;
      step_q  <= step_d;
      tgt_q   <= tgt_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
    end
  end

  // Tag delay lines aligning write-back strobes with datapath latency; abort flushes valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_vld_q <= '0;
      acc_dat_q <= '0;
      pos_vld_q <= '0;
      pos_dat_q <= '0;
    end else begin
      acc_vld_q <= bus.abort ? '0 : {acc_vld_q[AD-2:0], state_q == ACCEL};
      acc_dat_q <= {acc_dat_q[AD-2:0], {tgt_q, pair_first, row_end}};
      pos_vld_q <= bus.abort ? '0 : {pos_vld_q[PD-2:0], state_q == POS};
      pos_dat_q <= {pos_dat_q[PD-2:0], addr_q};
    end
  end

  assign bus.busy         = (state_q == ACCEL) || (state_q == DRAIN_A) ||
                            (state_q == POS)   || (state_q == DRAIN_P);
  assign bus.done         = (state_q == DONE);
  assign bus.step_idx     = step_q;
  assign bus.first_step   = bus.busy && (step_q == 16'd0);
  assign bus.rd_valid     = (state_q == ACCEL);
  assign bus.rd_tgt       = tgt_q;
  assign bus.rd_src       = src_q;
  assign bus.acc_valid    = acc_vld_q[AD-1];
  assign bus.acc_tgt      = acc_dat_q[AD-1][AW+1:2];
  assign bus.acc_first    = acc_dat_q[AD-1][1];
  assign bus.acc_last     = acc_dat_q[AD-1][0];
  assign bus.pos_rd_valid = (state_q == POS);
  assign bus.pos_rd_addr  = addr_q;
  assign bus.pos_wr_en    = pos_vld_q[PD-1];
  assign bus.pos_wr_addr  = pos_dat_q[PD-1];
endmodule

// File: tb/tb_nbody_step_scheduler.sv
// Bench for nbody_step_scheduler with short latencies (RAM=1, ACCL=5, ADD=3).
// Latency: reference model predicts every strobe's cycle from the scheduling rules.
// Backpressure: none exercised; scheduler has no ready inputs.
module tb_nbody_step_scheduler;
  localparam int AW = 4;
  localparam int RL = 1;
  localparam int AL = 5;
  localparam int DL = 3;
  localparam int D1 = RL + AL;
  localparam int D2 = RL + DL;
`ifdef NBODY_SKIP_SELF_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed { int cyc; int a; int b; int c; } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  nbody_step_scheduler_if #(.AW(AW)) bus();

  nbody_step_scheduler #(
    .BODIES(16), .BODY_ADDR_WIDTH(AW),
    .RAM_LATENCY(RL), .ACCL_LATENCY(AL), .ADD_LATENCY(DL)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log captured mid-cycle
  ev_t got_rd[$], got_acc[$], got_prd[$], got_pwr[$];
  ev_t exp_rd[$], exp_acc[$], exp_prd[$], exp_pwr[$];
  bit  log_en = 1'b0;
  int  log_from = 0;
  bit  done_seen = 1'b0;
  int  done_cyc = 0;
  int  busy_cnt = 0;
  int  fs_cnt = 0;
  int  last_sc = 0;

  always @(negedge clk) begin
    if (log_en && cyc > log_from) begin
      if (bus.rd_valid)     got_rd.push_back('{cyc, int'(bus.rd_tgt), int'(bus.rd_src), int'(bus.step_idx)});
      if (bus.acc_valid)    got_acc.push_back('{cyc, int'(bus.acc_tgt), int'(bus.acc_first), int'(bus.acc_last)});
      if (bus.pos_rd_valid) got_prd.push_back('{cyc, int'(bus.pos_rd_addr), 0, 0});
      if (bus.pos_wr_en)    got_pwr.push_back('{cyc, int'(bus.pos_wr_addr), 0, 0});
      if (bus.busy)         busy_cnt++;
      if (bus.first_step)   fs_cnt++;
      if (bus.done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  task automatic log_clear();
    got_rd.delete(); got_acc.delete(); got_prd.delete(); got_pwr.delete();
    exp_rd.delete(); exp_acc.delete(); exp_prd.delete(); exp_pwr.delete();
    done_seen = 1'b0; busy_cnt = 0; fs_cnt = 0; done_cyc = 0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_bodies = '0; bus.n_steps = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++;
      $display("FAIL reset_status busy=%b done=%b required 0/0", bus.busy, bus.done); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.acc_valid !== 1'b0 || bus.pos_rd_valid !== 1'b0 || bus.pos_wr_en !== 1'b0) begin failures++;
      $display("FAIL reset_strobes rd=%b acc=%b prd=%b pwr=%b required 0", bus.rd_valid, bus.acc_valid, bus.pos_rd_valid, bus.pos_wr_en); end
    checks++; if (bus.step_idx !== 16'd0 || bus.first_step !== 1'b0) begin failures++;
      $display("FAIL reset_step step_idx=%0d first_step=%b required 0/0", bus.step_idx, bus.first_step); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0/0", bus.busy, bus.done); end
  endtask

  // One complete run checked against the reference schedule; bogus_at>0 pulses a start mid-run.
  task automatic test_run(input int n, input int steps, input int bogus_at);
    int sc, t, t0, ps, p, dc, busy_e, fs_e, budget, st, fsrc, lsrc;
    log_clear();
    st = (steps == 0) ? 1 : steps;
    @(negedge clk);
    sc = cyc; last_sc = sc; log_from = sc; log_en = 1'b1;
    bus.num_bodies = (AW+1)'(n); bus.n_steps = 16'(steps); bus.start = 1'b1;
    // Reference schedule
    t = sc + 1; busy_e = 0; fs_e = 0;
    if (n == 0) begin
      dc = sc + 1;
    end else begin
      for (int s = 0; s < st; s++) begin
        t0 = t; p = 0;
        for (int tg = 0; tg < n; tg++) begin
          fsrc = (SKIP && tg == 0) ? 1 : 0;
          lsrc = (SKIP && tg == n - 1) ? n - 2 : n - 1;
          for (int sr = 0; sr < n; sr++) begin
            if (SKIP && sr == tg) continue;
            exp_rd.push_back('{t, tg, sr, s});
            exp_acc.push_back('{t + D1, tg, int'(sr == fsrc), int'(sr == lsrc)});
            t++; p++;
          end
        end
        ps = (p > 0) ? t + D1 : t0 + 1;
        for (int i = 0; i < n; i++) begin
          exp_prd.push_back('{ps + i, i, 0, 0});
          exp_pwr.push_back('{ps + i + D2, i, 0, 0});
        end
        t = ps + n + D2;
        busy_e += t - t0;
        if (s == 0) fs_e = t - t0;
      end
      dc = t;
    end
    budget = dc - sc + 20;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < budget && !done_seen; i++) begin
      @(negedge clk);
      bus.start = (bogus_at > 0 && cyc == sc + bogus_at);
      bus.num_bodies = bus.start ? (AW+1)'(2) : (AW+1)'(n);
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    log_en = 1'b0;
    checks++; if (!done_seen || done_cyc !== dc) begin failures++;
      $display("FAIL done_cycle n=%0d got seen=%0d cyc=%0d required cyc=%0d", n, done_seen, done_cyc - sc, dc - sc); end
    checks++; if (got_rd.size() !== exp_rd.size() || got_acc.size() !== exp_acc.size()) begin failures++;
      $display("FAIL pair_count n=%0d got rd=%0d acc=%0d required %0d/%0d", n, got_rd.size(), got_acc.size(), exp_rd.size(), exp_acc.size()); end
    checks++; if (got_prd.size() !== exp_prd.size() || got_pwr.size() !== exp_pwr.size()) begin failures++;
      $display("FAIL pos_count n=%0d got rd=%0d wr=%0d required %0d/%0d", n, got_prd.size(), got_pwr.size(), exp_prd.size(), exp_pwr.size()); end
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
      checks++; if (got_rd[i] !== exp_rd[i]) begin failures++;
        $display("FAIL rd[%0d] got cyc=%0d tgt=%0d src=%0d step=%0d required cyc=%0d tgt=%0d src=%0d step=%0d", i,
          got_rd[i].cyc - sc, got_rd[i].a, got_rd[i].b, got_rd[i].c, exp_rd[i].cyc - sc, exp_rd[i].a, exp_rd[i].b, exp_rd[i].c); end
    end
    for (int i = 0; i < exp_acc.size() && i < got_acc.size(); i++) begin
      checks++; if (got_acc[i] !== exp_acc[i]) begin failures++;
        $display("FAIL acc[%0d] got cyc=%0d tgt=%0d first=%0d last=%0d required cyc=%0d tgt=%0d first=%0d last=%0d", i,
          got_acc[i].cyc - sc, got_acc[i].a, got_acc[i].b, got_acc[i].c, exp_acc[i].cyc - sc, exp_acc[i].a, exp_acc[i].b, exp_acc[i].c); end
    end
    for (int i = 0; i < exp_prd.size() && i < got_prd.size(); i++) begin
      checks++; if (got_prd[i] !== exp_prd[i] || got_pwr[i] !== exp_pwr[i]) begin failures++;
        $display("FAIL pos[%0d] got rd cyc=%0d addr=%0d wr cyc=%0d addr=%0d required %0d/%0d %0d/%0d", i,
          got_prd[i].cyc - sc, got_prd[i].a, got_pwr[i].cyc - sc, got_pwr[i].a, exp_prd[i].cyc - sc, exp_prd[i].a, exp_pwr[i].cyc - sc, exp_pwr[i].a); end
    end
    checks++; if (busy_cnt !== busy_e || fs_cnt !== fs_e) begin failures++;
      $display("FAIL busy_first_step n=%0d got busy=%0d first=%0d required %0d/%0d", n, busy_cnt, fs_cnt, busy_e, fs_e); end
  endtask

  task automatic test_plan_timing();
    int lasts[$];
    int want[4];
    want[0] = 10; want[1] = 14; want[2] = 18; want[3] = 22;
    test_run(4, 1, 0);
    foreach (got_acc[i]) if (got_acc[i].c == 1) lasts.push_back(got_acc[i].cyc - last_sc);
    checks++; if (lasts.size() !== 4) begin failures++;
      $display("FAIL plan_acc_last_count got %0d required 4", lasts.size()); end
    for (int i = 0; i < 4 && i < lasts.size(); i++) begin
      checks++; if (lasts[i] !== want[i]) begin failures++;
        $display("FAIL plan_acc_last[%0d] got cycle %0d required %0d", i, lasts[i], want[i]); end
    end
    checks++; if (done_cyc - last_sc !== 31) begin failures++;
      $display("FAIL plan_done got cycle %0d required 31", done_cyc - last_sc); end
  endtask

  task automatic test_abort();
    int sc, late_acc, late_rd;
    log_clear();
    @(negedge clk);
    sc = cyc; log_from = sc; log_en = 1'b1;
    bus.num_bodies = (AW+1)'(4); bus.n_steps = 16'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && cyc < sc + 10; i++) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++;
      $display("FAIL abort_idle busy=%b done=%b required 0/0", bus.busy, bus.done); end
    repeat (30) @(negedge clk);
    log_en = 1'b0;
    late_acc = 0; late_rd = 0;
    foreach (got_acc[i]) if (got_acc[i].cyc >= sc + 11) late_acc++;
    foreach (got_rd[i])  if (got_rd[i].cyc >= sc + 11) late_rd++;
    checks++; if (late_acc !== 0 || late_rd !== 0 || got_prd.size() !== 0) begin failures++;
      $display("FAIL abort_strobes late_acc=%0d late_rd=%0d pos_rd=%0d required 0", late_acc, late_rd, got_prd.size()); end
    checks++; if (got_rd.size() !== 10 || got_acc.size() !== 4 || done_seen !== 1'b0) begin failures++;
      $display("FAIL abort_counts rd=%0d acc=%0d done=%0d required 10/4/0", got_rd.size(), got_acc.size(), done_seen); end
    test_run(3, 2, 0);
  endtask

  task automatic test_reset_mid_pos();
    int n;
    @(negedge clk);
    bus.num_bodies = (AW+1)'(4); bus.n_steps = 16'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (n = 0; n < 100 && !bus.pos_rd_valid; n++) @(negedge clk);
    checks++; if (bus.pos_rd_valid !== 1'b1) begin failures++;
      $display("FAIL reach_pos timeout pos_rd_valid=%b required 1", bus.pos_rd_valid); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.pos_rd_valid !== 1'b0 || bus.pos_wr_en !== 1'b0 || bus.acc_valid !== 1'b0 || bus.done !== 1'b0) begin failures++;
      $display("FAIL async_reset busy=%b prd=%b pwr=%b acc=%b done=%b required 0", bus.busy, bus.pos_rd_valid, bus.pos_wr_en, bus.acc_valid, bus.done); end
    checks++; if (bus.pos_rd_addr !== '0 || bus.pos_wr_addr !== '0 || bus.step_idx !== 16'd0) begin failures++;
      $display("FAIL async_reset_addr prd=%0d pwr=%0d step=%0d required 0", bus.pos_rd_addr, bus.pos_wr_addr, bus.step_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    test_run(2, 1, 0);
  endtask

  initial begin
    int n, s;
    test_reset();
    test_plan_timing();
    test_run(4, 3, 0);
    test_run(0, 1, 0);
    test_run(1, 1, 0);
    test_run(3, 0, 0);
    test_abort();
    test_run(4, 1, 5);
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 6);
      s = $urandom_range(1, 3);
      test_run(n, s, 0);
    end
    test_reset_mid_pos();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nbody_step_scheduler.md
# nbody_step_scheduler

Sequencer for the n-body integration datapath. It runs one timestep at a time. First it issues every (target, source) body pair to the acceleration/velocity pipeline. Then it issues every body to the position-update adder. It tracks pipeline latency with tag delay lines, so downstream RAMs receive correctly aligned write addresses and enables. It sits between the bus register file (which supplies start, body count and step count) and the RAM/getAccl/AddSub datapath.

## Interface
- BODIES, 512: maximum body count.
- BODY_ADDR_WIDTH, $clog2(BODIES): body index width.
- RAM_LATENCY, 1: cycles from RAM address to read data.
- ACCL_LATENCY, 123: cycles from getAccl inputs to ax/ay.
- ADD_LATENCY, 20: AddSub latency.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- abort  in  1  stops the run and returns to IDLE.
- num_bodies  in  BODY_ADDR_WIDTH+1  body count N, latched on start.
- n_steps  in  16  timesteps to run, latched on start; 0 is treated as 1.
- busy  out  1  high in ACCEL, DRAIN_A, POS, DRAIN_P.
- done  out  1  high in DONE.
- step_idx  out  16  current step, zero-based.
- first_step  out  1  high while step_idx==0 (datapath applies the half-kick).
- rd_valid, rd_tgt, rd_src  out  1/BODY_ADDR_WIDTH/BODY_ADDR_WIDTH  pair-read issue.
- acc_valid, acc_tgt  out  1/BODY_ADDR_WIDTH  delayed velocity write-back for a pair.
- acc_first, acc_last  out  1/1  the delayed pair is the first/last source for its target.
- pos_rd_valid, pos_rd_addr  out  1/BODY_ADDR_WIDTH  position/velocity read issue.
- pos_wr_en, pos_wr_addr  out  1/BODY_ADDR_WIDTH  delayed position write.

## Operation
- States: IDLE, ACCEL, DRAIN_A, POS, DRAIN_P, DONE.
- Reset values: state=IDLE. All outputs 0. Delay lines cleared.
- IDLE/DONE + start:
  - Latch N and n_steps; step_idx=0.
  - If N==0, go to DONE. Otherwise go to ACCEL with tgt=0, src=0.
  - start while busy is ignored.
- ACCEL:
  - Issues one pair per cycle: rd_valid=1, outer loop tgt 0..N-1, inner loop src 0..N-1.
  - After the pair (N-1, N-1) is issued, go to DRAIN_A.
- Accel delay line: depth RAM_LATENCY+ACCL_LATENCY; carries {valid, tgt, first, last}.
  - Output drives acc_*.
- DRAIN_A: stays until the delay line holds no valid entry, then goes to POS with addr=0.
- POS:
  - pos_rd_valid=1, pos_rd_addr 0..N-1, one per cycle.
  - After N-1 is issued, go to DRAIN_P.
- Pos delay line: depth RAM_LATENCY+ADD_LATENCY; drives pos_wr_en and pos_wr_addr.
- DRAIN_P, when the pos delay line is empty:
  - If step_idx==n_steps_eff-1, go to DONE.
  - Else step_idx+1 and go to ACCEL with tgt=src=0.
- DONE: holds until start (new run) or abort (go to IDLE).
- abort in any state:
  - Next state IDLE; all delay-line valid bits cleared the same edge.
  - No further rd/acc/pos strobes; done stays 0.
  - abort has priority over start in the same cycle.
- Counters and indices are unsigned. Index wrap compares against N-1, never against BODIES.
- N=1: a single pair (0,0) with acc_first=acc_last=1.

## Timing
- A start sampled at edge c puts the first rd_valid at cycle c+1.
- A pair issued at cycle k produces acc_valid at k+RAM_LATENCY+ACCL_LATENCY.
- A pos read issued at k produces pos_wr_en at k+RAM_LATENCY+ADD_LATENCY.
- Per-step cycle count (no skip): N²+RAM_LATENCY+ACCL_LATENCY+N+RAM_LATENCY+ADD_LATENCY.
- DRAIN to next phase: the phase change happens on the cycle after the last delayed valid; there are no idle cycles beyond that.
- done asserts on the cycle after the final pos_wr_en.
- rst_n deasserted mid-run: everything returns to reset values immediately (asynchronous).

## Configuration
- NBODY_SKIP_SELF_EN defined:
  - The scheduler skips pairs with src==tgt; no rd_valid is issued for them and no cycle is spent on them.
  - Each target gets N-1 pairs. acc_first/acc_last refer to the first/last non-self source.
  - N=1 yields zero pairs: ACCEL goes straight to DRAIN_A.
- Not defined: all N² pairs are issued; the datapath zeroes self-interaction.

## Test plan
- RAM_LATENCY=1, ACCL=5, ADD=3, N=4, n_steps=1, start at cycle 0 -> rd_valid cycles 1–16; acc_valid cycles 7–22 (acc_last at 10,14,18,22); pos_rd 23–26; pos_wr_en 27–30 addr 0..3; done=1 at cycle 31.
- Same config, n_steps=3 -> step_idx 0,1,2; first_step high only during step 0; done after 3×30 cycles of busy.
- N=0 start -> done=1 next cycle; no rd/acc/pos strobes.
- abort asserted at cycle 10 of the first test -> state IDLE at cycle 11; acc_valid never high from cycle 11; done=0; a new start runs cleanly.
- NBODY_SKIP_SELF_EN, N=3 -> six pairs in order (0,1),(0,2),(1,0),(1,2),(2,0),(2,1); acc_first on (0,1),(1,0),(2,0).
- start pulsed while busy, and rst_n pulsed mid-POS -> start ignored; reset forces all outputs to 0 asynchronously.
